// File: rtl/dense_flatten_collector_if.sv
// Stream-in / frame-out bundle for dense_flatten_collector.
// Master drives the word stream and takes the frame; slave is the collector.
interface dense_flatten_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUMS       = 1600
);
  logic [DATA_WIDTH-1:0]      in_data_i;
  logic                       in_valid_i;
  logic                       in_sof_i;
  logic                       in_ready_o;
  logic [DATA_WIDTH*NUMS-1:0] vec_data_o;
  logic                       vec_valid_o;
  logic                       vec_ready_i;
  logic                       sof_err_o;

  modport master (
    output in_data_i, in_valid_i, in_sof_i, vec_ready_i,
    input  in_ready_o, vec_data_o, vec_valid_o, sof_err_o
  );

  modport slave (
    input  in_data_i, in_valid_i, in_sof_i, vec_ready_i,
    output in_ready_o, vec_data_o, vec_valid_o, sof_err_o
  );
endinterface

// File: rtl/dense_flatten_collector.sv
// Collects a plane-ordered pooled feature map and re-packs it channel-last
// into one wide frame vector for dense_top.
module dense_flatten_collector #(
  parameter int H          = 5,
  parameter int W          = 5,
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rstn_i,
  dense_flatten_collector_if.slave bus
);
  localparam int NUMS = DEPTH * H * W;
  localparam int DCW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HCW  = (H > 1) ? $clog2(H) : 1;
  localparam int WCW  = (W > 1) ? $clog2(W) : 1;
  localparam int PW   = $clog2(NUMS) + 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]     r_state;
  logic [DCW-1:0] r_d;
  logic [HCW-1:0] r_h;
  logic [WCW-1:0] r_w;
  logic           r_err;

  logic [NUMS-1:0][DATA_WIDTH-1:0] r_buf;

  logic           w_xfer;
  logic           w_zero;
  logic           w_restart;
  logic           w_err;
  logic           w_last;
  logic [DCW-1:0] w_d_e;
  logic [HCW-1:0] w_h_e;
  logic [WCW-1:0] w_w_e;
  logic [DCW-1:0] w_d_n;
  logic [HCW-1:0] w_h_n;
  logic [WCW-1:0] w_w_n;
  logic [PW-1:0]  w_slot;

  // Effective write position, flatten slot and next counter values
  always_comb begin
    w_xfer    = bus.in_valid_i && (r_state == FILL);
    w_zero    = (r_d == '0) && (r_h == '0) && (r_w == '0);
    w_restart = bus.in_sof_i && !w_zero;
    w_err     = w_xfer && (bus.in_sof_i != w_zero);
    w_d_e     = w_restart ? '0 : r_d;
    w_h_e     = w_restart ? '0 : r_h;
    w_w_e     = w_restart ? '0 : r_w;
    w_last    = (w_d_e == DCW'(DEPTH - 1))
             && (w_h_e == HCW'(H - 1))
             && (w_w_e == WCW'(W - 1));
    w_slot    = (PW'(w_h_e) * PW'(W) + PW'(w_w_e))
              * PW'(DEPTH) + PW'(w_d_e);
    w_d_n     = w_d_e;
    w_h_n     = w_h_e;
    w_w_n     = w_w_e;
    if (w_last) begin
      w_d_n = '0;
      w_h_n = '0;
      w_w_n = '0;
    end else if (w_w_e == WCW'(W - 1)) begin
      w_w_n = '0;
      if (w_h_e == HCW'(H - 1)) begin
        w_h_n = '0;
        w_d_n = w_d_e + 1'b1;
      end else begin
        w_h_n = w_h_e + 1'b1;
      end
    end else begin
      w_w_n = w_w_e + 1'b1;
    end
  end

  // Fill/hold state, position counters and the sync-error pulse
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= FILL;
      r_d     <= '0;
      r_h     <= '0;
      r_w     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (r_state == FULL) begin
        if (bus.vec_ready_i) r_state <= FILL;
      end else if (w_xfer) begin
        r_d <= w_d_n;
        r_h <= w_h_n;
        r_w <= w_w_n;
        if (w_last) r_state <= FULL;
      end
    end
  end

  for (genvar k = 0; k < NUMS; k++) begin : g_slot
    // Slot k captures the accepted word whose flatten index is k
    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
        r_buf[k] <= '0;
      end else if (w_xfer && (w_slot == PW'(k))) begin
        r_buf[k] <= bus.in_data_i;
      end
    end
  end

  assign bus.in_ready_o  = (r_state == FILL);
  assign bus.vec_valid_o = (r_state == FULL);
  assign bus.vec_data_o  = r_buf;
  assign bus.sof_err_o   = r_err;
endmodule

// File: tb/tb_dense_flatten_collector.sv
// Directed bench for dense_flatten_collector: a 2x2x2 byte instance
// for reorder/handshake/sync cases and a default-size instance.
module tb_dense_flatten_collector;
  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;
  int   errs  = 0;

  always #5 clk = ~clk;

  dense_flatten_collector_if #(.DATA_WIDTH(8), .NUMS(8)) bs ();
  dense_flatten_collector_if #(.DATA_WIDTH(32), .NUMS(1600)) bb ();

  dense_flatten_collector #(
    .H(2), .W(2), .DEPTH(2), .DATA_WIDTH(8)
  ) dut_s (
    .clk(clk),
    .rstn_i(rstn),
    .bus(bs.slave)
  );

  dense_flatten_collector dut_b (
    .clk(clk),
    .rstn_i(rstn),
    .bus(bb.slave)
  );

  always @(negedge clk) if (bs.sof_err_o === 1'b1) errs++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_s(input logic [7:0] d, input logic sof);
    int n = 0;
    bs.in_data_i  = d;
    bs.in_sof_i   = sof;
    bs.in_valid_i = 1'b1;
    while (bs.in_ready_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("send_s_timeout", 64'(bs.in_ready_o), 64'd1);
    step();
    bs.in_valid_i = 1'b0;
    bs.in_sof_i   = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic sof);
    int n = 0;
    bb.in_data_i  = d;
    bb.in_sof_i   = sof;
    bb.in_valid_i = 1'b1;
    while (bb.in_ready_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("send_b_timeout", 64'(bb.in_ready_o), 64'd1);
    step();
    bb.in_valid_i = 1'b0;
    bb.in_sof_i   = 1'b0;
  endtask

  // channel-last slot k holds stream word (k%2)*4 + k/2
  function automatic logic [63:0] frame(input logic [7:0] base);
    logic [63:0] r;
    for (int k = 0; k < 8; k++)
      r[k*8 +: 8] = base + 8'((k % 2) * 4 + k / 2);
    return r;
  endfunction

  task automatic chk_vec(input string tag, input logic [63:0] e);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s[%0d]", tag, k),
          64'(bs.vec_data_o[k*8 +: 8]), 64'(e[k*8 +: 8]));
  endtask

  task automatic handoff(input string tag);
    bs.vec_ready_i = 1'b1;
    step();
    bs.vec_ready_i = 1'b0;
    chk({tag, "_valid_low"}, 64'(bs.vec_valid_o), 64'd0);
    chk({tag, "_ready_high"}, 64'(bs.in_ready_o), 64'd1);
  endtask

  initial begin
    logic [63:0] ref_v;
    int e0;
    rstn           = 1'b0;
    bs.in_data_i   = '0;
    bs.in_valid_i  = 1'b0;
    bs.in_sof_i    = 1'b0;
    bs.vec_ready_i = 1'b0;
    bb.in_data_i   = '0;
    bb.in_valid_i  = 1'b0;
    bb.in_sof_i    = 1'b0;
    bb.vec_ready_i = 1'b0;
    step();
    step();
    chk("rst_ready", 64'(bs.in_ready_o), 64'd1);
    chk("rst_valid", 64'(bs.vec_valid_o), 64'd0);
    chk("rst_err", 64'(bs.sof_err_o), 64'd0);
    chk("rst_vec", bs.vec_data_o, 64'd0);
    chk("rst_b_ready", 64'(bb.in_ready_o), 64'd1);
    chk("rst_b_valid", 64'(bb.vec_valid_o), 64'd0);
    rstn = 1'b1;
    step();

    // reorder
    e0 = errs;
    for (int i = 0; i < 8; i++) begin
      send_s(8'(i), i == 0);
      if (i == 6) chk("reo_valid_early", 64'(bs.vec_valid_o), 64'd0);
    end
    chk("reo_valid", 64'(bs.vec_valid_o), 64'd1);
    chk("reo_ready", 64'(bs.in_ready_o), 64'd0);
    ref_v = 64'h07_03_06_02_05_01_04_00;
    chk_vec("reo", ref_v);
    chk("reo_errs", 64'(errs - e0), 64'd0);

    // backpressure
    bs.in_valid_i = 1'b1;
    bs.in_data_i  = 8'hFF;
    bs.in_sof_i   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("bp_ready[%0d]", c), 64'(bs.in_ready_o), 64'd0);
    end
    chk("bp_valid", 64'(bs.vec_valid_o), 64'd1);
    chk_vec("bp", ref_v);
    bs.vec_ready_i = 1'b1;
    step();
    bs.vec_ready_i = 1'b0;
    bs.in_valid_i  = 1'b0;
    bs.in_sof_i    = 1'b0;
    chk("bp_rel_valid", 64'(bs.vec_valid_o), 64'd0);
    chk("bp_rel_ready", 64'(bs.in_ready_o), 64'd1);
    chk_vec("bp_kept", ref_v);

    // resync
    e0 = errs;
    send_s(8'h10, 1'b1);
    send_s(8'h11, 1'b0);
    send_s(8'h12, 1'b0);
    send_s(8'hA0, 1'b1);
    chk("rs_err_pulse", 64'(bs.sof_err_o), 64'd1);
    for (int i = 1; i < 8; i++) send_s(8'hA0 + 8'(i), 1'b0);
    chk("rs_valid", 64'(bs.vec_valid_o), 64'd1);
    chk("rs_errs", 64'(errs - e0), 64'd1);
    chk_vec("rs", frame(8'hA0));
    handoff("rs");

    // missing sof straight after reset
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    e0 = errs;
    send_s(8'h30, 1'b0);
    chk("ms_err_pulse", 64'(bs.sof_err_o), 64'd1);
    for (int i = 1; i < 8; i++) send_s(8'h30 + 8'(i), 1'b0);
    chk("ms_valid", 64'(bs.vec_valid_o), 64'd1);
    chk("ms_errs", 64'(errs - e0), 64'd1);
    chk_vec("ms", frame(8'h30));
    handoff("ms");

    // gapped input
    e0 = errs;
    for (int i = 0; i < 8; i++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      send_s(8'(i), i == 0);
    end
    chk("gap_valid", 64'(bs.vec_valid_o), 64'd1);
    chk("gap_errs", 64'(errs - e0), 64'd0);
    chk_vec("gap", ref_v);

    // async reset while holding a frame
    #3;
    rstn = 1'b0;
    #1;
    chk("ar_full_valid", 64'(bs.vec_valid_o), 64'd0);
    chk("ar_full_ready", 64'(bs.in_ready_o), 64'd1);
    chk("ar_full_vec", bs.vec_data_o, 64'd0);
    step();
    rstn = 1'b1;

    // async reset mid-fill, then a clean frame
    send_s(8'h70, 1'b1);
    send_s(8'h71, 1'b0);
    send_s(8'h72, 1'b0);
    #3;
    rstn = 1'b0;
    #1;
    chk("ar_fill_ready", 64'(bs.in_ready_o), 64'd1);
    chk("ar_fill_valid", 64'(bs.vec_valid_o), 64'd0);
    step();
    rstn = 1'b1;
    step();
    e0 = errs;
    for (int i = 0; i < 8; i++) begin
      send_s(8'h50 + 8'(i), i == 0);
      if (i == 6) chk("ar_valid_early", 64'(bs.vec_valid_o), 64'd0);
    end
    chk("ar_valid", 64'(bs.vec_valid_o), 64'd1);
    chk("ar_errs", 64'(errs - e0), 64'd0);
    chk_vec("ar", frame(8'h50));
    handoff("ar");

    // default geometry: 5x5x64 of 32-bit words
    for (int i = 0; i < 1600; i++) send_b(32'(i), i == 0);
    chk("big_valid", 64'(bb.vec_valid_o), 64'd1);
    chk("big_ready", 64'(bb.in_ready_o), 64'd0);
    for (int p = 0; p < 1600; p++)
      chk($sformatf("big[%0d]", p), 64'(bb.vec_data_o[p*32 +: 32]),
          64'((p % 64) * 25 + p / 64));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
